// File: rtl/calc_operand_unit.sv
// rtl/calc_operand_unit.sv - calculator operand capture, ALU/shift-add multiply and display mux
// Operands enter one hex digit at a time; a trigger_op rising edge runs the latched operation.
module calc_operand_unit #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_trigger_1,
    input  logic             i_trigger_2,
    input  logic             i_trigger_op,
    input  logic [1:0]       i_estado,
    input  logic [3:0]       i_digit_in,
    input  logic [1:0]       i_op_code,
    output logic [WIDTH-1:0] o_display_value,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_digits_a,
    output logic [2:0]       o_digits_b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic [1:0]           r_op_q;
    logic                 r_trig_op_q;
    logic [1:0]           r_estado_q;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplr;
    logic [4:0]           r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_overflow;
    logic [2:0]           r_digits_a;
    logic [2:0]           r_digits_b;

    logic                 w_start;
    logic                 w_clear;
    logic                 w_abort;
    logic                 w_last;
    logic                 w_busy;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_busy  = (r_state == S_CALC);
    assign w_start = (r_state == S_IDLE) && i_trigger_op && !r_trig_op_q;
    assign w_clear = (r_estado_q == 2'd3) && (i_estado == 2'd0);
    assign w_abort = (r_state != S_IDLE) && !i_trigger_op;
    assign w_last  = w_busy && (r_cnt == 5'd15);

    // Carry and borrow fall out of bit WIDTH of the widened add/sub.
    assign w_sum      = {1'b0, r_op_a} + {1'b0, r_op_b};
    assign w_diff     = {1'b0, r_op_a} - {1'b0, r_op_b};
    assign w_acc_next = r_acc + (r_mplr[0] ? ({{WIDTH{1'b0}}, r_op_a} << r_cnt) : '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = (i_op_code == 2'b11) ? S_CALC : S_DONE;
            S_CALC: if (w_last)  w_next = S_DONE;
            S_DONE: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort || w_clear) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_q      <= '0;
            r_trig_op_q <= 1'b0;
            r_estado_q  <= '0;
            r_acc       <= '0;
            r_mplr      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_digits_a  <= '0;
            r_digits_b  <= '0;
        end else begin
            r_state     <= w_next;
            r_trig_op_q <= i_trigger_op;
            r_estado_q  <= i_estado;
            if (w_clear) begin
                r_op_a     <= '0;
                r_op_b     <= '0;
                r_digits_a <= '0;
                r_digits_b <= '0;
                r_result   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (!w_busy && i_trigger_1 && (r_digits_a < 3'd4)) begin
                    r_op_a     <= {r_op_a[WIDTH-5:0], i_digit_in};
                    r_digits_a <= r_digits_a + 3'd1;
                end
                if (!w_busy && i_trigger_2 && (r_digits_b < 3'd4)) begin
                    r_op_b     <= {r_op_b[WIDTH-5:0], i_digit_in};
                    r_digits_b <= r_digits_b + 3'd1;
                end
                if (w_abort) begin
                    r_result   <= '0;
                    r_overflow <= 1'b0;
                end else if (w_start) begin
                    r_op_q <= i_op_code;
                    r_acc  <= '0;
                    r_mplr <= r_op_b;
                    r_cnt  <= '0;
                    case (i_op_code)
                        2'b00: begin
                            r_result   <= w_sum[WIDTH-1:0];
                            r_overflow <= w_sum[WIDTH];
                        end
                        2'b01: begin
                            r_result   <= w_diff[WIDTH-1:0];
                            r_overflow <= w_diff[WIDTH];
                        end
                        2'b10: begin
                            r_result   <= r_op_a & r_op_b;
                            r_overflow <= 1'b0;
                        end
                        default: ;
                    endcase
                end else if (w_busy) begin
                    r_acc  <= w_acc_next;
                    r_mplr <= r_mplr >> 1;
                    r_cnt  <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_result   <= w_acc_next[WIDTH-1:0];
                        r_overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        o_display_value = '0;
        case (i_estado)
            2'd0: o_display_value = r_op_a;
            2'd1: o_display_value = r_op_b;
            2'd2: o_display_value = {{(WIDTH-2){1'b0}}, i_op_code};
            2'd3: o_display_value = (r_state == S_DONE) ? r_result : '0;
            default: o_display_value = '0;
        endcase
    end

    assign o_result   = r_result;
    assign o_overflow = r_overflow;
    assign o_busy     = w_busy;
    assign o_done     = (r_state == S_DONE);
    assign o_digits_a = r_digits_a;
    assign o_digits_b = r_digits_b;

endmodule

// File: tb/tb_calc_operand_unit.sv
// tb/tb_calc_operand_unit.sv - directed self-checking bench for calc_operand_unit
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_calc_operand_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        t1, t2, top;
    logic [1:0]  estado;
    logic [3:0]  digit;
    logic [1:0]  op_code;
    logic [15:0] display_value, result;
    logic        overflow, busy, done;
    logic [2:0]  digits_a, digits_b;

    int n_cmp = 0;
    int n_err = 0;

    calc_operand_unit #(.WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_trigger_1(t1), .i_trigger_2(t2),
        .i_trigger_op(top), .i_estado(estado), .i_digit_in(digit), .i_op_code(op_code),
        .o_display_value(display_value), .o_result(result), .o_overflow(overflow),
        .o_busy(busy), .o_done(done), .o_digits_a(digits_a), .o_digits_b(digits_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; t1 = 1'b0; t2 = 1'b0; top = 1'b0;
        estado = 2'd0; digit = 4'h0; op_code = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_a(input logic [15:0] v);
        estado = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            digit = v[4*i +: 4]; t1 = 1'b1; tick(); t1 = 1'b0;
        end
    endtask

    task automatic load_b(input logic [15:0] v);
        estado = 2'd1;
        for (int i = 3; i >= 0; i--) begin
            digit = v[4*i +: 4]; t2 = 1'b1; tick(); t2 = 1'b0;
        end
    endtask

    task automatic count_busy(input string tag, input int exp_cycles);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic [15:0] exp_res, input logic exp_ovf);
        do_reset();
        load_a(a);
        load_b(b);
        estado = 2'd2; op_code = op; top = 1'b1;
        tick();
        if (op == 2'b11) count_busy({tag, "_busy_cycles"}, 16);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_overflow"}, overflow, exp_ovf);
        top = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: reset state, digit entry with saturation, add
        do_reset();
        check("rst_result", result, 16'h0000);
        check("rst_flags", {overflow, busy, done}, 3'b000);
        check("rst_digits", {digits_a, digits_b}, 6'd0);
        check("rst_disp_a", display_value, 16'h0000);
        estado = 2'd3; #1;
        check("rst_disp_show_not_done", display_value, 16'h0000);
        estado = 2'd0;
        load_a(16'h1234);
        check("add_op_a", display_value, 16'h1234);
        check("add_digits_a", digits_a, 3'd4);
        digit = 4'h9; t1 = 1'b1; tick(); t1 = 1'b0;
        check("fifth_digit_ignored", display_value, 16'h1234);
        check("digits_a_saturated", digits_a, 3'd4);
        load_b(16'h0FFF);
        check("add_op_b", display_value, 16'h0FFF);
        check("add_digits_b", digits_b, 3'd4);
        estado = 2'd2; op_code = 2'b00; top = 1'b1;
        tick();
        check("add_done", done, 1'b1);
        check("add_result", result, 16'h2233);
        check("add_overflow", overflow, 1'b0);
        top = 1'b0; tick();
        check("abort_from_done", {done, result}, 17'h0_0000);

        // Test 2/3: sub borrow, add carry, multiply
        run_op("sub_borrow", 16'h0003, 16'h0005, 2'b01, 16'hFFFE, 1'b1);
        run_op("add_carry", 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1);
        run_op("mul_ffff", 16'h00FF, 16'h0101, 2'b11, 16'hFFFF, 1'b0);
        run_op("mul_ovf", 16'h1000, 16'h0010, 2'b11, 16'h0000, 1'b1);

        // Test 4: abort in 8th busy cycle, triggers ignored while busy, restart
        do_reset();
        load_a(16'h00FF);
        load_b(16'h0101);
        estado = 2'd2; op_code = 2'b11; top = 1'b1;
        tick();
        op_code = 2'b00;
        digit = 4'hF; t1 = 1'b1; tick(); t1 = 1'b0;
        check("busy_trigger_ignored", digits_a, 3'd4);
        for (int i = 0; i < 6; i++) tick();
        check("busy_before_abort", busy, 1'b1);
        top = 1'b0;
        tick();
        check("abort_flags", {busy, done}, 2'b00);
        check("abort_result", result, 16'h0000);
        estado = 2'd0; #1;
        check("abort_keeps_a", display_value, 16'h00FF);
        estado = 2'd2; op_code = 2'b11; top = 1'b1;
        tick();
        op_code = 2'b10;
        count_busy("restart_busy_cycles", 16);
        check("restart_result", result, 16'hFFFF);
        check("restart_done", done, 1'b1);

        // Test 5: display mux, AND, clear beats trigger
        do_reset();
        load_a(16'hABCD);
        check("mux_a", display_value, 16'hABCD);
        load_b(16'h0003);
        check("mux_b", display_value, 16'h0003);
        estado = 2'd2; op_code = 2'b10; #1;
        check("mux_opcode", display_value, 16'h0002);
        top = 1'b1;
        tick();
        estado = 2'd3; #1;
        check("mux_result_and", display_value, 16'h0001);
        tick();
        estado = 2'd0; top = 1'b0; digit = 4'h5; t1 = 1'b1;
        tick();
        t1 = 1'b0;
        check("clear_digits", {digits_a, digits_b}, 6'd0);
        check("clear_op_a", display_value, 16'h0000);
        check("clear_state", {done, overflow, result}, 18'h0);
        estado = 2'd1; #1;
        check("clear_op_b", display_value, 16'h0000);

        // Test 6: simultaneous triggers, reset mid-multiply
        do_reset();
        digit = 4'h7; t1 = 1'b1; t2 = 1'b1;
        tick();
        t1 = 1'b0; t2 = 1'b0;
        check("simul_digits", {digits_a, digits_b}, {3'd1, 3'd1});
        estado = 2'd0; #1;
        check("simul_op_a", display_value, 16'h0007);
        estado = 2'd1; #1;
        check("simul_op_b", display_value, 16'h0007);
        estado = 2'd2; op_code = 2'b11; top = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("mid_mul_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_mul_flags", {busy, done, overflow}, 3'b000);
        check("rst_mid_mul_result", result, 16'h0000);
        check("rst_mid_mul_digits", {digits_a, digits_b}, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc_operand_unit.md
# calc_operand_unit

Datapath responder for the four-digit calculator sequencer. It consumes the sequencer's `trigger_1`, `trigger_2` and `trigger_op` outputs and its 2-bit `estado`. On these it captures two 16-bit operands one hex digit at a time, runs the selected operation (single-cycle add/sub/AND, or a 16-cycle shift-add multiply), and drives the 16-bit value shown on the display.

## Interface
- `WIDTH`, default 16: operand and result width; fixed at 16, four hex digits per operand.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset. **Synchronous, active-high.**
- `trigger_1`  in  1: one-cycle pulse; shift `digit_in` into operand A.
- `trigger_2`  in  1: one-cycle pulse; shift `digit_in` into operand B.
- `trigger_op`  in  1: level signal, high during the sequencer's compute and show phases. Its rising edge starts a computation.
- `estado`  in  2: sequencer phase. 0 = entry A, 1 = entry B, 2 = compute, 3 = show result.
- `digit_in`  in  4: hex digit from the switches.
- `op_code`  in  2: operation select. 00 = add, 01 = sub (A−B), 10 = AND, 11 = multiply.
- `display_value`  out  16: value for the 7-segment driver.
- `result`  out  16: registered operation result.
- `overflow`  out  1: result flag; meaning is defined per operation under Operation.
- `busy`  out  1: high while a multiply is iterating.
- `done`  out  1: high from result valid until the unit is cleared or the computation is aborted.
- `digits_a`, `digits_b`  out  3 each: number of digits captured, 0..4.

## Operation
**Internal state**
- `op_a`, `op_b`: 16-bit operands.
- `op_q`: latched op code, 2 bits.
- `trig_op_q`: registered `trigger_op`.
- `estado_q`: registered `estado`.
- Multiply registers: 32-bit accumulator, 16-bit multiplier shift register, 5-bit iteration counter.
- FSM with states IDLE, CALC, DONE.

**Digit entry**
- On a `trigger_1` pulse with `digits_a` < 4:
  - `op_a <= {op_a[11:0], digit_in}`
  - `digits_a` increments by 1.
- On a `trigger_1` pulse with `digits_a` = 4, the pulse is ignored; `op_a` is unchanged.
- `trigger_2` does the same for `op_b` and `digits_b`.
- Both triggers in the same cycle: both are applied.
- Triggers are ignored while `busy` = 1.

**Start**
- A start occurs when `trigger_op` = 1 and `trig_op_q` = 0 while the FSM is in IDLE.
- In the start cycle, `op_q <= op_code`. Later changes on `op_code` have no effect.
- Op 00, 01 or 10: IDLE → DONE. `result` and `overflow` are written in the same cycle.
  - Add: `result` = A+B, low 16 bits; `overflow` = carry out.
  - Sub: `result` = A−B, mod 2^16; `overflow` = borrow (A < B).
  - AND: `result` = A&B; `overflow` = 0.
- Op 11: IDLE → CALC.
  - The accumulator loads 0 and the multiplier register loads B.
  - Each CALC cycle: if the multiplier LSB is 1, add A shifted left by the iteration index into the accumulator. Then shift the multiplier right by one and increment the counter.
  - After 16 iterations: CALC → DONE, `result` = accumulator[15:0], `overflow` = |accumulator[31:16].

**DONE**
- Holds `result`, `overflow` and `done` = 1.
- A further rising edge of `trigger_op` is impossible without first leaving DONE, so no restart occurs.

**Abort**
- `trigger_op` = 0 while the FSM is in CALC or DONE → IDLE next cycle.
- `busy` and `done` clear. `result` and `overflow` clear to 0.
- Operands are kept.

**Clear**
- Triggered when `estado_q` = 3 and `estado` = 0; this is the sequencer wrapping to a new calculation.
- Next cycle: `op_a`, `op_b`, the digit counts, `result`, `overflow` and `done` are all 0, and the FSM is in IDLE.
- Clear has priority over any trigger in the same cycle.

**Display mux (combinational on `estado`)**
- `estado` 0 → `op_a`.
- `estado` 1 → `op_b`.
- `estado` 2 → {14'b0, `op_code`}: shows the live selection.
- `estado` 3 → `result` when `done` = 1, else 16'h0000.

## Timing
- Reset: every register is 0 and the FSM is in IDLE. All outputs read 0.
- A `rst` asserted mid-multiply overrides everything else.
- Digit capture: the register and count update on the clock edge that samples the trigger. The new value is visible on the following cycle.
- Start edge detected in cycle N:
  - Add, sub and AND: `done` = 1 and `result` valid in cycle N+1.
  - Multiply: `busy` = 1 in cycles N+1..N+16; `done` = 1 and `result` valid in cycle N+17, with `busy` = 0.
- Abort and clear take effect one cycle after the condition is sampled.
- Outputs are registered except `display_value`, which is a combinational mux.

## Test plan
1. **Add.** After `rst`, pulse `trigger_1` four times with digits 1,2,3,4 → `op_a` = 16'h1234, `digits_a` = 4. A fifth pulse with digit 9 leaves `op_a` = 16'h1234. Enter B = 16'h0FFF, `estado` = 2, `op_code` = 00, raise `trigger_op` → `result` = 16'h2233, `overflow` = 0, `done` = 1 one cycle later.
2. **Sub with borrow.** A = 16'h0003, B = 16'h0005, `op_code` = 01 → `result` = 16'hFFFE, `overflow` = 1. Add with A = 16'hFFFF, B = 16'h0001 → `result` = 16'h0000, `overflow` = 1.
3. **Multiply.** A = 16'h00FF, B = 16'h0101, `op_code` = 11 → `busy` high for exactly 16 cycles, then `result` = 16'hFFFF, `overflow` = 0. Repeat with A = 16'h1000, B = 16'h0010 → `result` = 16'h0000, `overflow` = 1.
4. **Abort.** Start a multiply, then drop `trigger_op` in the 8th busy cycle → IDLE next cycle, with `busy` = 0, `done` = 0, `result` = 0. A new rising edge restarts the multiply and it completes correctly.
5. **Clear and display mux.** Step `estado` 0→1→2→3 and check `display_value` shows A, then B, then `op_code`, then `result`. Step `estado` 3→0 while pulsing `trigger_1` in the same cycle → operands and counts are 0 and the pulse is ignored.
6. **Simultaneous triggers and reset mid-multiply.** Pulse `trigger_1` and `trigger_2` together with digit 7 → `op_a` = `op_b` = 16'h0007. Assert `rst` mid-multiply → all outputs are 0 on the next cycle.
